// File: rtl/pc_seq.sv
// pc_seq: program counter for the lab CPU.
// It supports sequential advance, absolute jumps, and conditional PC-relative
// branches. CALL and RET go through an internal return-address stack. The
// reset vector can be configured.
// Optional feature: define PC_TRACE_EN to add last_src_pc, which holds the PC
// the most recent taken transfer left from (used for branch-trace debug).
module pc_seq #(
    parameter int AWIDTH = 16,
    parameter int OFFW = 8,
    parameter int STACK_DEPTH = 4,
    parameter logic [AWIDTH-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic [2:0]        pc_op,
    input  logic [AWIDTH-1:0] target_addr,
    input  logic [OFFW-1:0]   rel_offset,
    input  logic              cond_in,
    output logic [AWIDTH-1:0] pc_out,
    output logic              pc_jump,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
`ifdef PC_TRACE_EN
    ,
    output logic [AWIDTH-1:0] last_src_pc
`endif
);

    // Pointer spans 0..STACK_DEPTH inclusive, so it needs one value more than the entry count
    localparam int PW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_JMP  = 3'b010,
        OP_BR   = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_t;

    op_t               op;
    logic [PW-1:0]     ptr;
    logic [AWIDTH-1:0] stack_mem [2**PW];
    logic [AWIDTH-1:0] pc_plus_one;
    logic [AWIDTH-1:0] offset_ext;
    logic [AWIDTH-1:0] pop_value;
    logic [AWIDTH-1:0] pc_next;
    logic              taken;
    logic              hold_jump;
    logic              push;
    logic              pop;
    logic              err_set;

    assign op          = op_t'(pc_op);
    assign pc_plus_one = pc_out + AWIDTH'(1);
    assign offset_ext  = AWIDTH'($signed(rel_offset));
    assign pop_value   = stack_mem[ptr - PW'(1)];
    assign stack_full  = (ptr == PW'(STACK_DEPTH));
    assign stack_empty = (ptr == '0);

    // Decode the operation into the next PC, the jump flag, stack motion and error
    always_comb begin
        pc_next   = pc_out;
        taken     = 1'b0;
        hold_jump = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        case (op)
            OP_HOLD: ;
            OP_INC:  pc_next = pc_plus_one;
            OP_JMP: begin
                pc_next = target_addr;
                taken   = 1'b1;
            end
            OP_BR: begin
                if (cond_in) begin
                    pc_next = pc_out + offset_ext;
                    taken   = 1'b1;
                end else begin
                    pc_next = pc_plus_one;
                end
            end
            OP_CALL: begin
                if (!stack_full) begin
                    pc_next = target_addr;
                    taken   = 1'b1;
                    push    = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            OP_RET: begin
                if (!stack_empty) begin
                    pc_next = pop_value;
                    taken   = 1'b1;
                    pop     = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: hold_jump = 1'b1;
        endcase
    end

    // Register the PC, jump flag, stack pointer and sticky error on enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out    <= RESET_ADDR;
            pc_jump   <= 1'b0;
            stack_err <= 1'b0;
            ptr       <= '0;
        end else if (en_in) begin
            pc_out  <= pc_next;
            pc_jump <= hold_jump ? pc_jump : taken;
            if (err_set) begin
                stack_err <= 1'b1;
            end
            if (push) begin
                ptr <= ptr + PW'(1);
            end else if (pop) begin
                ptr <= ptr - PW'(1);
            end
        end
    end

    // Write the return address into the stack storage; contents need no reset
    always_ff @(posedge clk) begin
        if (en_in && push) begin
            stack_mem[ptr] <= pc_plus_one;
        end
    end

`ifdef PC_TRACE_EN
    // Remember where the most recent taken transfer came from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src_pc <= RESET_ADDR;
        end else if (en_in && taken) begin
            last_src_pc <= pc_out;
        end
    end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed self-checking bench for pc_seq.
// RESET_ADDR is 0x0100 and the stack depth is 4.
// When PC_TRACE_EN is defined, the bench also checks last_src_pc.
module tb_pc_seq;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_RSV6 = 3'b110;

    logic        clk;
    logic        rst_n;
    logic        en_in;
    logic [2:0]  pc_op;
    logic [15:0] target_addr;
    logic [7:0]  rel_offset;
    logic        cond_in;
    logic [15:0] pc_out;
    logic        pc_jump;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;
`ifdef PC_TRACE_EN
    logic [15:0] last_src_pc;
`endif

    int total;
    int bad;

    pc_seq #(
        .AWIDTH(16),
        .OFFW(8),
        .STACK_DEPTH(4),
        .RESET_ADDR(16'h0100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_in(en_in),
        .pc_op(pc_op),
        .target_addr(target_addr),
        .rel_offset(rel_offset),
        .cond_in(cond_in),
        .pc_out(pc_out),
        .pc_jump(pc_jump),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .stack_err(stack_err)
`ifdef PC_TRACE_EN
        ,
        .last_src_pc(last_src_pc)
`endif
    );

    // Free-running clock with a 10-time-unit period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] op, input logic [15:0] tgt,
                                 input logic [7:0] off, input logic cond);
        en_in       = en;
        pc_op       = op;
        target_addr = tgt;
        rel_offset  = off;
        cond_in     = cond;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        en_in       = 1'b0;
        pc_op       = OP_HOLD;
        target_addr = '0;
        rel_offset  = '0;
        cond_in     = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("rst_pc", pc_out, 32'h0100);
        checkOutput("rst_jump", pc_jump, 0);
        checkOutput("rst_empty", stack_empty, 1);
        checkOutput("rst_full", stack_full, 0);
        checkOutput("rst_err", stack_err, 0);
`ifdef PC_TRACE_EN
        checkOutput("rst_trace", last_src_pc, 32'h0100);
`endif
        rst_n = 1'b1;

        // Three increments from the reset vector
        for (int i = 0; i < 3; i++) applyStimulus(1, OP_INC, 16'h0, 8'h0, 0);
        checkOutput("inc3_pc", pc_out, 32'h0103);
        checkOutput("inc3_jump", pc_jump, 0);
        checkOutput("inc3_empty", stack_empty, 1);
        checkOutput("inc3_err", stack_err, 0);

        // Negative branch, then a branch that is not taken
        applyStimulus(1, OP_JMP, 16'h0010, 8'h0, 0);
        checkOutput("jmp10_pc", pc_out, 32'h0010);
        checkOutput("jmp10_jump", pc_jump, 1);
        applyStimulus(1, OP_BR, 16'h0, 8'hFC, 1);
        checkOutput("br_neg_pc", pc_out, 32'h000C);
        checkOutput("br_neg_jump", pc_jump, 1);
        applyStimulus(1, OP_BR, 16'h0, 8'hFC, 0);
        checkOutput("br_nt_pc", pc_out, 32'h000D);
        checkOutput("br_nt_jump", pc_jump, 0);

        // Wrap-around on increment and on a negative branch below zero
        applyStimulus(1, OP_JMP, 16'hFFFF, 8'h0, 0);
        applyStimulus(1, OP_INC, 16'h0, 8'h0, 0);
        checkOutput("inc_wrap_pc", pc_out, 32'h0000);
        applyStimulus(1, OP_BR, 16'h0, 8'h80, 1);
        checkOutput("br_wrap_pc", pc_out, 32'hFF80);
        checkOutput("br_wrap_jump", pc_jump, 1);

        // HOLD clears the jump flag; a reserved op keeps pc and jump flag
        applyStimulus(1, OP_HOLD, 16'h1234, 8'h0, 0);
        checkOutput("hold_pc", pc_out, 32'hFF80);
        checkOutput("hold_jump", pc_jump, 0);
        applyStimulus(1, OP_JMP, 16'h0020, 8'h0, 0);
        applyStimulus(1, OP_RSV6, 16'h1234, 8'h0, 0);
        checkOutput("rsv_pc", pc_out, 32'h0020);
        checkOutput("rsv_jump", pc_jump, 1);
        checkOutput("rsv_empty", stack_empty, 1);

        // Nested calls fill the stack
        applyStimulus(1, OP_CALL, 16'h0100, 8'h0, 0);
        checkOutput("call1_pc", pc_out, 32'h0100);
        checkOutput("call1_empty", stack_empty, 0);
        applyStimulus(1, OP_CALL, 16'h0200, 8'h0, 0);
        applyStimulus(1, OP_CALL, 16'h0300, 8'h0, 0);
        checkOutput("call3_full", stack_full, 0);
        applyStimulus(1, OP_CALL, 16'h0400, 8'h0, 0);
        checkOutput("call4_pc", pc_out, 32'h0400);
        checkOutput("call4_jump", pc_jump, 1);
        checkOutput("call4_full", stack_full, 1);
        checkOutput("call4_err", stack_err, 0);
        applyStimulus(1, OP_CALL, 16'h0500, 8'h0, 0);
        checkOutput("call5_pc", pc_out, 32'h0400);
        checkOutput("call5_jump", pc_jump, 0);
        checkOutput("call5_err", stack_err, 1);
        checkOutput("call5_full", stack_full, 1);

        // Unwind the stack in LIFO order
        applyStimulus(1, OP_RET, 16'h0, 8'h0, 0);
        checkOutput("ret1_pc", pc_out, 32'h0301);
        checkOutput("ret1_jump", pc_jump, 1);
        checkOutput("ret1_full", stack_full, 0);
        applyStimulus(1, OP_RET, 16'h0, 8'h0, 0);
        checkOutput("ret2_pc", pc_out, 32'h0201);
        applyStimulus(1, OP_RET, 16'h0, 8'h0, 0);
        checkOutput("ret3_pc", pc_out, 32'h0101);
        applyStimulus(1, OP_RET, 16'h0, 8'h0, 0);
        checkOutput("ret4_pc", pc_out, 32'h0021);
        checkOutput("ret4_empty", stack_empty, 1);

        // Underflow keeps the pc, and the error flag stays set
        applyStimulus(1, OP_RET, 16'h0, 8'h0, 0);
        checkOutput("ret_empty_pc", pc_out, 32'h0021);
        checkOutput("ret_empty_jump", pc_jump, 0);
        checkOutput("ret_empty_err", stack_err, 1);
        applyStimulus(1, OP_INC, 16'h0, 8'h0, 0);
        applyStimulus(1, OP_INC, 16'h0, 8'h0, 0);
        checkOutput("sticky_pc", pc_out, 32'h0023);
        checkOutput("sticky_err", stack_err, 1);

        // Jump, then check that a disabled cycle holds every register
        applyStimulus(1, OP_JMP, 16'h0042, 8'h0, 0);
        checkOutput("jmp42_pc", pc_out, 32'h0042);
`ifdef PC_TRACE_EN
        checkOutput("trace_23", last_src_pc, 32'h0023);
`endif
        applyStimulus(0, OP_JMP, 16'h0555, 8'h0, 0);
        checkOutput("dis_pc", pc_out, 32'h0042);
        checkOutput("dis_jump", pc_jump, 1);
        applyStimulus(0, OP_CALL, 16'h0666, 8'h0, 0);
        checkOutput("dis_call_empty", stack_empty, 1);
        applyStimulus(1, OP_JMP, 16'h0555, 8'h0, 0);
        checkOutput("jmp555_pc", pc_out, 32'h0555);
`ifdef PC_TRACE_EN
        checkOutput("trace_42", last_src_pc, 32'h0042);
`endif

        // Asynchronous reset in the middle of a call sequence
        applyStimulus(1, OP_CALL, 16'h0700, 8'h0, 0);
        applyStimulus(1, OP_CALL, 16'h0800, 8'h0, 0);
        checkOutput("mid_pc", pc_out, 32'h0800);
        checkOutput("mid_empty", stack_empty, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("arst_pc", pc_out, 32'h0100);
        checkOutput("arst_empty", stack_empty, 1);
        checkOutput("arst_full", stack_full, 0);
        checkOutput("arst_err", stack_err, 0);
        checkOutput("arst_jump", pc_jump, 0);
`ifdef PC_TRACE_EN
        checkOutput("arst_trace", last_src_pc, 32'h0100);
`endif
        rst_n = 1'b1;
        applyStimulus(1, OP_RET, 16'h0, 8'h0, 0);
        checkOutput("post_rst_ret_pc", pc_out, 32'h0100);
        checkOutput("post_rst_ret_err", stack_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
